// File: rtl/fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_writer_if
// Description : Pixel-stream and framebuffer write-port bundle for fb_writer.
//               master : the frame writer (accepts pixels, issues writes)
//               slave  : the environment (pixel source + framebuffer memory)
//   pix_valid  source has a pixel on pix_data
//   pix_data   15-bit BGR555 pixel, raster order
//   pix_ready  writer accepts pix_data this cycle
//   mem_busy   framebuffer write port unavailable this cycle
//   wr_en      framebuffer write strobe
//   wr_addr    framebuffer word address
//   wr_data    framebuffer word {1'b0, pixel}
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_writer_if;
    logic        pix_valid;
    logic [14:0] pix_data;
    logic        pix_ready;
    logic        mem_busy;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        input  pix_valid, pix_data, mem_busy,
        output pix_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output pix_valid, pix_data, mem_busy,
        input  pix_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : fb_writer
// Description : Accepts one frame of raster-ordered BGR555 pixels through a
//               small FIFO and writes them to consecutive framebuffer words
//               starting at address 0.
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   frame_start  one-cycle request to begin a new frame (honoured in IDLE)
//   bus          fb_writer_if.master : pixel stream in, memory writes out
//   busy         high whenever the writer is not IDLE
//   frame_done   one-cycle pulse after the frame's final write
// Revision    : 1.0 - initial release
// ============================================================================
module fb_writer #(
    parameter int FB_W       = 240,
    parameter int FB_H       = 160,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    fb_writer_if.master bus,
    output logic        busy,
    output logic        frame_done
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FB_W * FB_H + 1);

    localparam logic [c_CNT_W-1:0] c_TOTAL     = c_CNT_W'(FB_W * FB_H);
    localparam logic [c_CNT_W-1:0] c_LAST_ACC  = c_CNT_W'(FB_W * FB_H - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [15:0]        c_LAST_ADDR = 16'(FB_W * FB_H - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_PTR_ONE   = (c_PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [14:0]          r_fifo [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_PTR_W:0]     r_wptr;
    logic [c_PTR_W:0]     r_rptr;
    logic [c_CNT_W-1:0]   r_acc_cnt;
    logic [15:0]          r_addr;

    logic [c_PTR_W:0]     w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_count == c_DEPTH);

    // Ready looks at occupancy only: a full FIFO that pops this cycle still
    // refuses the incoming pixel.
    assign w_ready = (r_state == S_ACTIVE) && !w_full && (r_acc_cnt < c_TOTAL);
    assign w_push  = bus.pix_valid && w_ready;
    assign w_pop   = !w_empty && !bus.mem_busy;

    assign bus.pix_ready = w_ready;
    assign bus.wr_en     = w_pop;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = {1'b0, r_fifo[r_rptr[c_PTR_W-1:0]]};

    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

    // Pixel storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[c_PTR_W-1:0]] <= bus.pix_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_acc_cnt <= '0;
            r_addr    <= '0;
        end else if (r_state == S_IDLE) begin
            if (frame_start) begin
                r_state   <= S_ACTIVE;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_acc_cnt <= '0;
                r_addr    <= '0;
            end
        end else begin
            if (w_push) begin
                r_wptr    <= r_wptr + c_PTR_ONE;
                r_acc_cnt <= r_acc_cnt + c_CNT_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
                // Address holds on the final word so it never points past
                // the end of the frame.
                if (r_addr != c_LAST_ADDR) begin
                    r_addr <= r_addr + 16'd1;
                end
            end
            case (r_state)
                S_ACTIVE: begin
                    if (w_push && (r_acc_cnt == c_LAST_ACC)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // No pushes in FLUSH, so a pop at occupancy 1 empties it.
                    if (w_pop && (w_count == c_PTR_ONE)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_writer
// Description : Self-checking bench for fb_writer. A default-size instance
//               covers the full 240x160 frame, stall and reset scenarios; a
//               small 12x5 instance runs randomized valid/busy frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

    localparam int A_N = 240 * 160;
    localparam int B_W = 12;
    localparam int B_H = 5;
    localparam int B_N = B_W * B_H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic fs_a, fs_b;
    logic busy_a, busy_b, done_a, done_b;

    fb_writer_if ifa ();
    fb_writer_if ifb ();

    fb_writer u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .frame_start (fs_a),
        .bus         (ifa.master),
        .busy        (busy_a),
        .frame_done  (done_a)
    );

    fb_writer #(
        .FB_W       (B_W),
        .FB_H       (B_H),
        .FIFO_DEPTH (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .frame_start (fs_b),
        .bus         (ifb.master),
        .busy        (busy_b),
        .frame_done  (done_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] pa [A_N];
    logic [14:0] pb [B_N];

    // Apply inputs mid-cycle; outputs are sampled 1 ns later, far from posedge.
    task automatic drive_a(input logic v, input logic [14:0] d, input logic mb, input logic fs);
        @(negedge clk);
        ifa.pix_valid = v; ifa.pix_data = d; ifa.mem_busy = mb; fs_a = fs;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [14:0] d, input logic mb, input logic fs);
        @(negedge clk);
        ifb.pix_valid = v; ifb.pix_data = d; ifb.mem_busy = mb; fs_b = fs;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0;
        ifa.pix_valid = 1'b0; ifa.pix_data = '0; ifa.mem_busy = 1'b0;
        ifb.pix_valid = 1'b0; ifb.pix_data = '0; ifb.mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (ifa.pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_a: got %b want 0", ifa.pix_ready); end
        n_cmp++; if (ifa.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en_a: got %b want 0", ifa.wr_en); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done_a: got %b want 0", done_a); end
        n_cmp++; if (ifb.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en_b: got %b want 0", ifb.wr_en); end
        n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        @(negedge clk);
        rst = 1'b0;
        // Idle with no frame_start: pixels offered must not be taken.
        drive_a(1'b1, 15'h1234, 1'b0, 1'b0);
        n_cmp++; if (ifa.pix_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready_a: got %b want 0", ifa.pix_ready); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL idle_busy_a: got %b want 0", busy_a); end
        drive_a(1'b0, 15'h0, 1'b0, 1'b0);
    endtask

    // Full default frame, source always valid, memory always free, with a
    // stray frame_start in the middle that must be ignored.
    task automatic test_full_frame();
        int si, wi, n_done, first_wr, last_wr, done_cyc;
        logic [15:0] d240, last_addr;
        bit pulsed;
        logic fs;
        si = 0; wi = 0; n_done = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        d240 = '0; last_addr = '0; pulsed = 1'b0;
        for (int i = 0; i < A_N; i++) pa[i] = 15'($urandom);
        pa[240] = 15'h7C00;

        drive_a(1'b1, pa[0], 1'b0, 1'b1);
        n_cmp++; if (ifa.pix_ready !== 1'b0) begin n_err++; $display("FAIL start_cycle_ready: got %b want 0", ifa.pix_ready); end

        for (int cyc = 1; cyc < A_N + 10; cyc++) begin
            fs = (si == 20000) && !pulsed;
            if (fs) pulsed = 1'b1;
            drive_a(1'b1, (si < A_N) ? pa[si] : 15'h0, 1'b0, fs);
            if (ifa.wr_en) begin
                n_cmp++;
                if (wi >= A_N) begin
                    n_err++; $display("FAIL full_extra_write: addr %0d after %0d writes", ifa.wr_addr, wi);
                end else if (ifa.wr_addr !== 16'(wi) || ifa.wr_data !== {1'b0, pa[wi]}) begin
                    n_err++; $display("FAIL full_write: got addr %0d data %h want addr %0d data %h",
                                      ifa.wr_addr, ifa.wr_data, wi, {1'b0, pa[wi]});
                end
                if (wi == 0) first_wr = cyc;
                if (wi == 240) d240 = ifa.wr_data;
                last_addr = ifa.wr_addr;
                last_wr = cyc;
                wi++;
            end
            if (done_a) begin n_done++; done_cyc = cyc; end
            n_cmp++;
            if (busy_a !== (done_cyc < 0 || done_cyc == cyc)) begin
                n_err++; $display("FAIL full_busy: cycle %0d got %b", cyc, busy_a);
            end
            if (ifa.pix_valid && ifa.pix_ready) begin
                if (si >= A_N) begin
                    n_cmp++; n_err++; $display("FAIL full_extra_accept: accepted %0d want %0d", si + 1, A_N);
                end
                si++;
            end
        end
        n_cmp++; if (wi != A_N) begin n_err++; $display("FAIL full_write_count: got %0d want %0d", wi, A_N); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL full_done_count: got %0d want 1", n_done); end
        n_cmp++; if (first_wr != 2) begin n_err++; $display("FAIL full_first_latency: got %0d want 2", first_wr); end
        n_cmp++; if (last_wr != A_N + 1) begin n_err++; $display("FAIL full_last_write_cycle: got %0d want %0d", last_wr, A_N + 1); end
        n_cmp++; if (done_cyc != last_wr + 1) begin n_err++; $display("FAIL full_done_timing: got %0d want %0d", done_cyc, last_wr + 1); end
        n_cmp++; if (d240 !== 16'h7C00) begin n_err++; $display("FAIL full_row1_col0: got %h want 7c00", d240); end
        n_cmp++; if (last_addr !== 16'd38399) begin n_err++; $display("FAIL full_last_addr: got %0d want 38399", last_addr); end
    endtask

    // Randomized valid/busy frames on the small instance.
    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            int si, wi, n_done, last_wr, done_cyc;
            logic v, mb;
            si = 0; wi = 0; n_done = 0; last_wr = -1; done_cyc = -1;
            for (int i = 0; i < B_N; i++) pb[i] = 15'($urandom);
            drive_b(1'($urandom_range(0, 1)), 15'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            n_cmp++; if (ifb.pix_ready !== 1'b0) begin n_err++; $display("FAIL rnd_start_ready: got %b want 0", ifb.pix_ready); end
            for (int cyc = 1; cyc < 3000; cyc++) begin
                v  = 1'($urandom_range(0, 1));
                mb = 1'($urandom_range(0, 1));
                drive_b(v, (v && si < B_N) ? pb[si] : 15'($urandom), mb, 1'b0);
                if (ifb.wr_en) begin
                    n_cmp++;
                    if (wi >= B_N) begin
                        n_err++; $display("FAIL rnd_extra_write: addr %0d after %0d writes", ifb.wr_addr, wi);
                    end else if (ifb.wr_addr !== 16'(wi) || ifb.wr_data !== {1'b0, pb[wi]}) begin
                        n_err++; $display("FAIL rnd_write: got addr %0d data %h want addr %0d data %h",
                                          ifb.wr_addr, ifb.wr_data, wi, {1'b0, pb[wi]});
                    end
                    n_cmp++;
                    if (mb !== 1'b0) begin n_err++; $display("FAIL rnd_write_while_busy: wr_en %b mem_busy %b", ifb.wr_en, mb); end
                    last_wr = cyc;
                    wi++;
                end
                if (done_b) begin n_done++; done_cyc = cyc; end
                n_cmp++;
                if (busy_b !== (done_cyc < 0 || done_cyc == cyc)) begin
                    n_err++; $display("FAIL rnd_busy: frame %0d cycle %0d got %b", f, cyc, busy_b);
                end
                if (ifb.pix_valid && ifb.pix_ready) begin
                    if (si >= B_N) begin
                        n_cmp++; n_err++; $display("FAIL rnd_extra_accept: accepted %0d want %0d", si + 1, B_N);
                    end
                    si++;
                end
                if (done_cyc >= 0 && cyc > done_cyc + 2) break;
            end
            n_cmp++; if (wi != B_N) begin n_err++; $display("FAIL rnd_write_count: frame %0d got %0d want %0d", f, wi, B_N); end
            n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL rnd_done_count: frame %0d got %0d want 1", f, n_done); end
            n_cmp++; if (done_cyc != last_wr + 1) begin n_err++; $display("FAIL rnd_done_timing: got %0d want %0d", done_cyc, last_wr + 1); end
            n_cmp++; if (ifb.wr_addr > 16'(B_N - 1)) begin n_err++; $display("FAIL rnd_addr_bound: got %0d want <= %0d", ifb.wr_addr, B_N - 1); end
        end
    endtask

    // Memory stall of 10 cycles from an empty FIFO, then a reset after 1000
    // accepted pixels, then a fresh frame that must restart at address 0.
    task automatic test_stall_reset();
        int si, wi, phase, k, n_acc, first_wr;
        logic v, mb;
        bit fin;
        si = 0; wi = 0; phase = 0; k = 0; n_acc = 0; fin = 1'b0; first_wr = -1;
        drive_a(1'b0, 15'h0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            v  = (phase != 1);
            mb = (phase == 2);
            drive_a(v, pa[si], mb, 1'b0);
            if (phase == 2) begin
                n_cmp++; if (ifa.wr_en !== 1'b0) begin n_err++; $display("FAIL stall_wr_en: step %0d got %b want 0", k, ifa.wr_en); end
                n_cmp++; if (ifa.pix_ready !== (k < 4)) begin n_err++; $display("FAIL stall_ready: step %0d got %b want %b", k, ifa.pix_ready, k < 4); end
            end
            if (phase == 3) begin
                n_cmp++; if (ifa.pix_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready: got %b want 0", ifa.pix_ready); end
                n_cmp++; if (ifa.wr_en !== 1'b1) begin n_err++; $display("FAIL release_wr_en: got %b want 1", ifa.wr_en); end
            end
            if (ifa.wr_en) begin
                n_cmp++;
                if (ifa.wr_addr !== 16'(wi) || ifa.wr_data !== {1'b0, pa[wi]}) begin
                    n_err++; $display("FAIL stall_write: got addr %0d data %h want addr %0d data %h",
                                      ifa.wr_addr, ifa.wr_data, wi, {1'b0, pa[wi]});
                end
                wi++;
            end
            if (ifa.pix_valid && ifa.pix_ready) begin
                si++;
                if (phase == 2) n_acc++;
            end
            case (phase)
                0: if (si == 500) phase = 1;
                1: phase = 2;
                2: begin k++; if (k == 10) phase = 3; end
                3: phase = 4;
                default: if (si == 1000) fin = 1'b1;
            endcase
        end
        n_cmp++; if (n_acc != 4) begin n_err++; $display("FAIL stall_accepts: got %0d want 4", n_acc); end
        n_cmp++; if (si != 1000) begin n_err++; $display("FAIL stall_reach_1000: got %0d want 1000", si); end

        // Reset lands between edges; its effect must be visible at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (ifa.wr_en !== 1'b0) begin n_err++; $display("FAIL async_rst_wr_en: got %b want 0", ifa.wr_en); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL async_rst_busy: got %b want 0", busy_a); end
        n_cmp++; if (ifa.pix_ready !== 1'b0) begin n_err++; $display("FAIL async_rst_ready: got %b want 0", ifa.pix_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive_a(1'b1, pa[0], 1'b0, 1'b0);
        n_cmp++; if (ifa.wr_en !== 1'b0) begin n_err++; $display("FAIL post_rst_wr_en: got %b want 0", ifa.wr_en); end

        si = 0; wi = 0;
        drive_a(1'b1, pa[0], 1'b0, 1'b1);
        for (int cyc = 1; cyc < 8; cyc++) begin
            drive_a(1'b1, pa[si], 1'b0, 1'b0);
            if (ifa.wr_en) begin
                n_cmp++;
                if (ifa.wr_addr !== 16'(wi) || ifa.wr_data !== {1'b0, pa[wi]}) begin
                    n_err++; $display("FAIL restart_write: got addr %0d data %h want addr %0d data %h",
                                      ifa.wr_addr, ifa.wr_data, wi, {1'b0, pa[wi]});
                end
                if (wi == 0) first_wr = cyc;
                wi++;
            end
            if (ifa.pix_valid && ifa.pix_ready) si++;
        end
        n_cmp++; if (first_wr != 2) begin n_err++; $display("FAIL restart_latency: got %0d want 2", first_wr); end
        drive_a(1'b0, 15'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_full_frame();
        test_random_frames();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter FB_W, default 240, frame width in pixels.
REQ-002 SHALL have parameter FB_H, default 160, frame height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle request to begin writing a new frame.
REQ-007 SHALL have port pix_valid  input  1  pixel source has a pixel on pix_data.
REQ-008 SHALL have port pix_data  input  15  BGR555 pixel, raster order (row-major, col 0 first).
REQ-009 SHALL have port pix_ready  output  1  block accepts pix_data this cycle.
REQ-010 SHALL have port mem_busy  input  1  framebuffer write port unavailable this cycle.
REQ-011 SHALL have port wr_en  output  1  framebuffer write strobe.
REQ-012 SHALL have port wr_addr  output  16  framebuffer word address.
REQ-013 SHALL have port wr_data  output  16  framebuffer word, {1'b0, pixel}.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of frame written.

Function
REQ-016 SHALL implement FSM states IDLE, ACTIVE, FLUSH, DONE.
REQ-017 IDLE: pix_ready=0; frame_start=1 -> ACTIVE next cycle; accept count, write address and FIFO cleared on entry to ACTIVE.
REQ-018 ACTIVE: pix_ready = FIFO not full AND accept count < FB_W*FB_H; a pixel is accepted iff pix_valid & pix_ready at a rising edge.
REQ-019 ACTIVE -> FLUSH at the edge accepting pixel number FB_W*FB_H-1 (38399 at defaults); pix_ready=0 in FLUSH.
REQ-020 FLUSH -> DONE at the edge issuing the final write (FIFO becomes empty); DONE -> IDLE unconditionally next cycle; frame_done=1 only in DONE.
REQ-021 wr_en SHALL be combinational: FIFO not empty AND mem_busy=0; wr_data = FIFO head with bit15=0; wr_addr = write address register.
REQ-022 Each edge with wr_en=1 SHALL pop the FIFO and increment write address by 1; no multiplier -- address equals row*FB_W+col by sequential increment.
REQ-023 Latency: pixel accepted at edge ending cycle N into empty FIFO with mem_busy=0 SHALL appear with wr_en=1 in cycle N+1.
REQ-024 Simultaneous push and pop SHALL leave FIFO occupancy unchanged; full FIFO with a pop in the same cycle SHALL still deassert pix_ready (ready depends on occupancy only).
REQ-025 mem_busy=1 SHALL hold wr_en=0 and freeze FIFO head/address; pixels keep being accepted until FIFO full; no pixel dropped or duplicated.
REQ-026 wr_addr SHALL never exceed FB_W*FB_H-1; no write after frame's final pixel; counters do not wrap within a frame.
REQ-027 frame_start while not IDLE SHALL be ignored; frame_start in IDLE concurrent with pix_valid SHALL not accept that pixel (pix_ready=0 in IDLE).
REQ-028 pix_data SHALL be sampled only on accepting edges; pix_valid without pix_ready has no effect.

Reset
REQ-029 rst=1 SHALL asynchronously force: state IDLE, FIFO empty, accept count 0, write address 0, pix_ready=0, wr_en=0, busy=0, frame_done=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no further writes; next frame starts at address 0 after frame_start.
REQ-031 Outputs SHALL be valid the first edge after rst deasserts; no synchronizer latency inside block.

Verification
REQ-032 Full frame, pix_valid=1, mem_busy=0: frame_start -> 38400 writes, addresses 0..38399 consecutive, wr_data[14:0] = pixel sent, frame_done one cycle after write to 38399.
REQ-033 Pixel row 1 col 0 (value 15'h7C00) -> write at wr_addr 240 with wr_data 16'h7C00; row 159 col 239 -> address 38399.
REQ-034 mem_busy=1 for 10 cycles mid-frame -> pix_ready drops after exactly 4 accepts, wr_en=0 for 10 cycles, then 4 buffered writes in order, no loss.
REQ-035 Random pix_valid and mem_busy (50%) over full frame -> scoreboard: every pixel written once, in order, correct address; busy high throughout.
REQ-036 rst pulse after 1000 accepted pixels -> wr_en=0, busy=0 immediately; new frame_start -> first write at address 0.
REQ-037 frame_start pulsed during ACTIVE -> ignored; frame still completes at 38400 writes, single frame_done.
